// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction/data requester ports and the shared memory port.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              req_inst;
    logic              req_data;
    logic [31:0]       addr_inst;
    logic [31:0]       addr_data;
    logic [31:0]       wdata_inst;
    logic [31:0]       wdata_data;
    logic [3:0]        we_inst;
    logic [3:0]        we_data;
    logic              gnt_inst;
    logic              gnt_data;
    logic              rvalid_inst;
    logic              rvalid_data;
    logic [31:0]       rdata_inst;
    logic [31:0]       rdata_data;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_inst, req_data, addr_inst, addr_data,
        input  wdata_inst, wdata_data, we_inst, we_data, mem_rdata,
        output gnt_inst, gnt_data, rvalid_inst, rvalid_data,
        output rdata_inst, rdata_data, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_inst, req_data, addr_inst, addr_data,
        output wdata_inst, wdata_data, we_inst, we_data, mem_rdata,
        input  gnt_inst, gnt_data, rvalid_inst, rvalid_data,
        input  rdata_inst, rdata_data, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction and data ports, with read-data return routed after MEM_LATENCY.
//
// last_gnt  | meaning
// PORT_INST | instruction port won most recently; data wins next contention
// PORT_DATA | data port won most recently; instruction wins next contention
module mem_port_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int MEM_LATENCY = 1
) (
    input  logic                aclk,
    input  logic                areset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    port_e                  last_gnt;
    port_e                  last_gnt_nxt;
    port_e                  sel;
    logic                   grant;
    logic                   grant_rd;
    logic [3:0]             cmd_we;
    logic [MEM_LATENCY-1:0] pipe_vld;
    logic [MEM_LATENCY-1:0] pipe_port;
    logic                   rv_inst;
    logic                   rv_data;
    logic                   unused_addr;

    // Byte offset and bits above the RAM size are deliberately dropped.
    assign unused_addr = ^{bus.addr_inst[31:ADDR_W+2], bus.addr_inst[1:0],
                           bus.addr_data[31:ADDR_W+2], bus.addr_data[1:0]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_gnt  <= PORT_INST;
            pipe_vld  <= '0;
            pipe_port <= '0;
        end else begin
            last_gnt     <= last_gnt_nxt;
            pipe_vld[0]  <= grant_rd;
            pipe_port[0] <= sel;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
        end
    end

    always_comb begin
        grant = 1'b0;
        sel   = PORT_INST;
        if (!areset) begin
            if (bus.req_inst && bus.req_data) begin
                grant = 1'b1;
                sel   = (last_gnt == PORT_INST) ? PORT_DATA : PORT_INST;
            end else if (bus.req_inst) begin
                grant = 1'b1;
                sel   = PORT_INST;
            end else if (bus.req_data) begin
                grant = 1'b1;
                sel   = PORT_DATA;
            end
        end
    end

    always_comb begin
        bus.gnt_inst  = 1'b0;
        bus.gnt_data  = 1'b0;
        bus.mem_en    = grant;
        cmd_we        = 4'h0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        last_gnt_nxt  = last_gnt;
        if (grant) begin
            last_gnt_nxt = sel;
            if (sel == PORT_INST) begin
                bus.gnt_inst  = 1'b1;
                cmd_we        = bus.we_inst;
                bus.mem_addr  = bus.addr_inst[ADDR_W+1:2];
                bus.mem_wdata = bus.wdata_inst;
            end else begin
                bus.gnt_data  = 1'b1;
                cmd_we        = bus.we_data;
                bus.mem_addr  = bus.addr_data[ADDR_W+1:2];
                bus.mem_wdata = bus.wdata_data;
            end
        end
        bus.mem_we = cmd_we;
        grant_rd   = grant && (cmd_we == 4'h0);
    end

    // Returns are masked while reset is held so stale stages never surface.
    assign rv_inst = !areset && pipe_vld[MEM_LATENCY-1] && (pipe_port[MEM_LATENCY-1] == 1'b0);
    assign rv_data = !areset && pipe_vld[MEM_LATENCY-1] && (pipe_port[MEM_LATENCY-1] == 1'b1);

    assign bus.rvalid_inst = rv_inst;
    assign bus.rvalid_data = rv_data;
    assign bus.rdata_inst  = rv_inst ? bus.mem_rdata : 32'h0;
    assign bus.rdata_data  = rv_data ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (memory latency 1 and 3) with identical requester traffic
// and compares every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        gi;
        logic        gd;
        logic        rvi;
        logic        rvd;
        logic [31:0] rdi;
        logic [31:0] rdd;
        logic        en;
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] wd;
    } obs_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic        mem_clr;
    logic        req_i, req_d;
    logic [31:0] addr_i, addr_d, wd_i, wd_d;
    logic [3:0]  we_i, we_d;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always #5 aclk = ~aclk;

    mem_port_arbiter_if #(.ADDR_W(12)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(12)) bus3 ();

    mem_port_arbiter #(.ADDR_W(12), .MEM_LATENCY(1)) dut1 (.aclk(aclk), .areset(areset), .bus(bus1));
    mem_port_arbiter #(.ADDR_W(12), .MEM_LATENCY(3)) dut3 (.aclk(aclk), .areset(areset), .bus(bus3));

    assign bus1.req_inst = req_i;   assign bus3.req_inst = req_i;
    assign bus1.req_data = req_d;   assign bus3.req_data = req_d;
    assign bus1.addr_inst = addr_i; assign bus3.addr_inst = addr_i;
    assign bus1.addr_data = addr_d; assign bus3.addr_data = addr_d;
    assign bus1.wdata_inst = wd_i;  assign bus3.wdata_inst = wd_i;
    assign bus1.wdata_data = wd_d;  assign bus3.wdata_data = wd_d;
    assign bus1.we_inst = we_i;     assign bus3.we_inst = we_i;
    assign bus1.we_data = we_d;     assign bus3.we_data = we_d;

    obs_t obs1, obs3;
    assign obs1 = {bus1.gnt_inst, bus1.gnt_data, bus1.rvalid_inst, bus1.rvalid_data,
                   bus1.rdata_inst, bus1.rdata_data, bus1.mem_en, bus1.mem_we,
                   bus1.mem_addr, bus1.mem_wdata};
    assign obs3 = {bus3.gnt_inst, bus3.gnt_data, bus3.rvalid_inst, bus3.rvalid_data,
                   bus3.rdata_inst, bus3.rdata_data, bus3.mem_en, bus3.mem_we,
                   bus3.mem_addr, bus3.mem_wdata};

    // Memory devices: synchronous RAM with read data delayed by the latency;
    // random filler on idle cycles so unguarded rdata would show up.
    logic [31:0] dmem1 [0:4095];
    logic [31:0] dmem3 [0:4095];
    logic [31:0] rp1;
    logic [31:0] rp3 [3];

    always @(posedge aclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) dmem1[i] <= 32'h0;
        end else if (bus1.mem_en && bus1.mem_we != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (bus1.mem_we[b]) dmem1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
        end
        rp1 <= (bus1.mem_en && bus1.mem_we == 4'h0) ? dmem1[bus1.mem_addr] : $urandom;
    end
    assign bus1.mem_rdata = rp1;

    always @(posedge aclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) dmem3[i] <= 32'h0;
        end else if (bus3.mem_en && bus3.mem_we != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (bus3.mem_we[b]) dmem3[bus3.mem_addr][8*b +: 8] <= bus3.mem_wdata[8*b +: 8];
        end
        rp3[0] <= (bus3.mem_en && bus3.mem_we == 4'h0) ? dmem3[bus3.mem_addr] : $urandom;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign bus3.mem_rdata = rp3[2];

    // Reference model state: word memory, last winner, and expected returns
    // keyed by the cycle they are due (modulo 8).
    logic [31:0] ref_mem [0:4095];
    logic        prev [2];
    logic        ev [2][8];
    logic        ep [2][8];
    logic [31:0] ed [2][8];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL L%0d cyc %0d %s: got %h expected %h", lat(k), cyc, nm, got, exp);
        end
    endtask

    task automatic check_one(input int k, input obs_t o);
        logic        g, p, rv;
        logic [31:0] ea, ewd;
        logic [3:0]  ewe;
        logic [11:0] eaddr;
        int          slot;
        g     = !areset && (req_i || req_d);
        p     = (req_i && req_d) ? ~prev[k] : req_d;
        ea    = g ? (p ? addr_d : addr_i) : 32'h0;
        ewe   = g ? (p ? we_d : we_i) : 4'h0;
        ewd   = g ? (p ? wd_d : wd_i) : 32'h0;
        eaddr = g ? ea[13:2] : 12'h0;
        chk(k, "gnt_inst",  32'(o.gi),   32'(g && !p));
        chk(k, "gnt_data",  32'(o.gd),   32'(g && p));
        chk(k, "mem_en",    32'(o.en),   32'(g));
        chk(k, "mem_we",    32'(o.we),   32'(ewe));
        chk(k, "mem_addr",  32'(o.addr), 32'(eaddr));
        chk(k, "mem_wdata", o.wd,        ewd);
        slot = cyc % 8;
        rv   = ev[k][slot] && !areset;
        chk(k, "rvalid_inst", 32'(o.rvi), 32'(rv && !ep[k][slot]));
        chk(k, "rvalid_data", 32'(o.rvd), 32'(rv && ep[k][slot]));
        chk(k, "rdata_inst",  o.rdi, (rv && !ep[k][slot]) ? ed[k][slot] : 32'h0);
        chk(k, "rdata_data",  o.rdd, (rv && ep[k][slot]) ? ed[k][slot] : 32'h0);
        ev[k][slot] = 1'b0;
        if (areset) begin
            prev[k] = 1'b0;
            for (int s = 0; s < 8; s++) ev[k][s] = 1'b0;
        end else if (g) begin
            prev[k] = p;
            if (ewe == 4'h0) begin
                slot        = (cyc + lat(k)) % 8;
                ev[k][slot] = 1'b1;
                ep[k][slot] = p;
                ed[k][slot] = ref_mem[eaddr];
            end else if (k == 0) begin
                for (int b = 0; b < 4; b++)
                    if (ewe[b]) ref_mem[eaddr][8*b +: 8] = ewd[8*b +: 8];
            end
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        check_one(0, obs1);
        check_one(1, obs3);
        cyc++;
    endtask

    task automatic adv();
        @(posedge aclk);
        #1;
    endtask

    task automatic step();
        tick();
        adv();
    endtask

    task automatic idle();
        req_i = 1'b0; req_d = 1'b0;
        addr_i = 32'h0; addr_d = 32'h0;
        wd_i = 32'h0; wd_d = 32'h0;
        we_i = 4'h0; we_d = 4'h0;
    endtask

    task automatic cmd_i(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        req_i = 1'b1; addr_i = a; we_i = w; wd_i = d;
    endtask

    task automatic cmd_d(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        req_d = 1'b1; addr_d = a; we_d = w; wd_d = d;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a       = $urandom;
        a[13:7] = 7'h0;
        return a;
    endfunction

    task automatic rand_cmd(output logic r, output logic [31:0] a, output logic [3:0] w, output logic [31:0] d);
        int sel;
        r   = ($urandom_range(0, 3) != 0);
        a   = rand_addr();
        sel = $urandom_range(0, 3);
        w   = (sel < 2) ? 4'h0 : (sel == 2) ? 4'hF : 4'($urandom_range(1, 15));
        d   = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic        exp_port [4];
        logic [31:0] exp_data [4];

        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            prev[k] = 1'b0;
            for (int s = 0; s < 8; s++) begin
                ev[k][s] = 1'b0; ep[k][s] = 1'b0; ed[k][s] = 32'h0;
            end
        end
        idle();
        areset  = 1'b1;
        mem_clr = 1'b1;
        step();
        step();
        mem_clr = 1'b0;
        areset  = 1'b0;

        // Contention straight out of reset: data first, then strict alternation.
        for (int i = 0; i < 6; i++) begin
            cmd_i(32'h40, 4'h0, 32'h0);
            cmd_d(32'h44, 4'h0, 32'h0);
            tick();
            chk(0, "lit_contend_gd",  32'(obs1.gd), 32'(i % 2 == 0));
            chk(0, "lit_contend_one", 32'(obs1.gi) + 32'(obs1.gd), 32'd1);
            chk(1, "lit_contend_gd",  32'(obs3.gd), 32'(i % 2 == 0));
            chk(0, "lit_contend_en",  32'(obs1.en), 32'd1);
            adv();
        end
        idle();
        for (int i = 0; i < 4; i++) step();

        // Single instruction read of word 4.
        cmd_d(32'h10, 4'hF, 32'hDEADBEEF);
        step();
        idle();
        cmd_i(32'h10, 4'h0, 32'h0);
        tick();
        chk(0, "lit_rd_gnt_inst", 32'(obs1.gi), 32'd1);
        chk(0, "lit_rd_mem_addr", 32'(obs1.addr), 32'd4);
        adv();
        idle();
        tick();
        chk(0, "lit_rd_rvalid_inst", 32'(obs1.rvi), 32'd1);
        chk(0, "lit_rd_rdata_inst",  obs1.rdi, 32'hDEADBEEF);
        chk(0, "lit_rd_rvalid_data", 32'(obs1.rvd), 32'd0);
        adv();
        for (int i = 0; i < 3; i++) step();

        // Write then read back on the data port.
        cmd_d(32'h20, 4'hF, 32'h12345678);
        step();
        idle();
        cmd_d(32'h20, 4'h0, 32'h0);
        step();
        idle();
        tick();
        chk(0, "lit_wr_rd_data", obs1.rdd, 32'h12345678);
        adv();
        for (int i = 0; i < 3; i++) step();

        // Partial byte write over an all-ones word.
        cmd_d(32'h30, 4'hF, 32'hFFFFFFFF);
        step();
        idle();
        cmd_d(32'h30, 4'b0010, 32'h0000AB00);
        tick();
        chk(0, "lit_byte_mem_we", 32'(obs1.we), 32'h2);
        adv();
        idle();
        cmd_d(32'h30, 4'h0, 32'h0);
        step();
        idle();
        tick();
        chk(0, "lit_byte_rdata", obs1.rdd, 32'hFFFFABFF);
        adv();
        for (int i = 0; i < 3; i++) step();

        // Four pipelined alternating reads through the latency-3 instance.
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_data = '{32'hDEADBEEF, 32'h12345678, 32'hFFFFABFF, 32'hDEADBEEF};
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i == 0) cmd_i(32'h10, 4'h0, 32'h0);
            if (i == 1) cmd_d(32'h20, 4'h0, 32'h0);
            if (i == 2) cmd_i(32'h30, 4'h0, 32'h0);
            if (i == 3) cmd_d(32'h10, 4'h0, 32'h0);
            tick();
            if (i >= 3) begin
                chk(1, "lit_pipe_rvalid_inst", 32'(obs3.rvi), 32'(!exp_port[i-3]));
                chk(1, "lit_pipe_rvalid_data", 32'(obs3.rvd), 32'(exp_port[i-3]));
                chk(1, "lit_pipe_rdata", exp_port[i-3] ? obs3.rdd : obs3.rdi, exp_data[i-3]);
            end
            adv();
        end
        idle();
        for (int i = 0; i < 2; i++) step();

        // Reset one cycle after a read is issued; the read must never return.
        cmd_i(32'h10, 4'h0, 32'h0);
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        idle();
        step();
        tick();
        chk(1, "lit_rst_no_rvalid", 32'(obs3.rvi) + 32'(obs3.rvd), 32'd0);
        adv();
        cmd_i(32'h40, 4'h0, 32'h0);
        cmd_d(32'h44, 4'h0, 32'h0);
        tick();
        chk(1, "lit_rst_data_first", 32'(obs3.gd), 32'd1);
        chk(0, "lit_rst_data_first", 32'(obs1.gd), 32'd1);
        adv();
        idle();
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            rand_cmd(req_i, addr_i, we_i, wd_i);
            rand_cmd(req_d, addr_d, we_d, wd_d);
            areset = ($urandom_range(0, 63) == 0);
            step();
        end
        idle();
        areset = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
